// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency memory port among NUM_CORES cores.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
module shared_mem_arbiter #(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                             clock,
    input  logic                             rstN,
    input  logic [NUM_CORES-1:0]             req,
    input  logic [NUM_CORES-1:0]             reqWe,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  reqAddr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  reqData,
    output logic [NUM_CORES-1:0]             gnt,
    output logic [NUM_CORES-1:0]             ack,
    output logic [DATA_WIDTH-1:0]            rdData,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            memAddr,
    output logic [DATA_WIDTH-1:0]            memWrData,
    output logic                             memWe,
    output logic                             memRe,
    input  logic [DATA_WIDTH-1:0]            memRdData
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [IDX_W-1:0]        r_last, w_last_nxt;
    logic                    r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;

    logic [NUM_CORES-1:0]    r_gnt, w_gnt_nxt;
    logic [NUM_CORES-1:0]    r_ack, w_ack_nxt;
    logic [DATA_WIDTH-1:0]   r_rdData, w_rdData_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [ADDR_WIDTH-1:0]   r_memAddr, w_memAddr_nxt;
    logic [DATA_WIDTH-1:0]   r_memWrData, w_memWrData_nxt;
    logic                    r_memWe, w_memWe_nxt;
    logic                    r_memRe, w_memRe_nxt;

    logic                    w_found;
    logic [IDX_W-1:0]        w_pick;
    logic [IDX_W-1:0]        w_cand;
    logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_CORES];
    logic [DATA_WIDTH-1:0]   w_data_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_addr_arr[g] = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[g] = reqData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the core after the last winner so that winner ends up lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            w_cand = IDX_W'((32'(r_last) + k) % NUM_CORES);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_cnt_nxt    = r_cnt;
        w_rdData_nxt = r_rdData;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ISSUE;
                    w_idx_nxt   = w_pick;
                    w_we_nxt    = reqWe[w_pick];
                    w_addr_nxt  = w_addr_arr[w_pick];
                    w_wdata_nxt = w_data_arr[w_pick];
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_W'(MEM_LATENCY);
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    if (!r_we) begin
                        w_rdData_nxt = memRdData;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = r_idx;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_gnt_nxt        = w_busy_nxt ? (NUM_CORES'(1) << w_idx_nxt) : '0;
        w_ack_nxt        = (w_state_nxt == S_DONE) ? (NUM_CORES'(1) << w_idx_nxt) : '0;
        w_memWe_nxt      = (w_state_nxt == S_ISSUE) && w_we_nxt;
        w_memRe_nxt      = (w_state_nxt == S_ISSUE) && !w_we_nxt;
        w_memAddr_nxt    = (w_state_nxt == S_ISSUE) ? w_addr_nxt : r_memAddr;
        w_memWrData_nxt  = (w_state_nxt == S_ISSUE) ? w_wdata_nxt : r_memWrData;
    end

    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_last      <= IDX_W'(NUM_CORES - 1);
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdData    <= '0;
            r_busy      <= 1'b0;
            r_memAddr   <= '0;
            r_memWrData <= '0;
            r_memWe     <= 1'b0;
            r_memRe     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_last      <= w_last_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rdData    <= w_rdData_nxt;
            r_busy      <= w_busy_nxt;
            r_memAddr   <= w_memAddr_nxt;
            r_memWrData <= w_memWrData_nxt;
            r_memWe     <= w_memWe_nxt;
            r_memRe     <= w_memRe_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdData    = r_rdData;
    assign busy      = r_busy;
    assign memAddr   = r_memAddr;
    assign memWrData = r_memWrData;
    assign memWe     = r_memWe;
    assign memRe     = r_memRe;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: transaction-level model checked every cycle,
// a fixed-latency memory responder, and directed scenarios with literal expectations.
module tb_shared_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int L  = 2;

    logic               clock = 1'b0;
    logic               rstN;
    logic [NC-1:0]      req;
    logic [NC-1:0]      reqWe;
    logic [NC*AW-1:0]   reqAddr;
    logic [NC*DW-1:0]   reqData;
    logic [NC-1:0]      gnt;
    logic [NC-1:0]      ack;
    logic [DW-1:0]      rdData;
    logic               busy;
    logic [AW-1:0]      memAddr;
    logic [DW-1:0]      memWrData;
    logic               memWe;
    logic               memRe;
    logic [DW-1:0]      memRdData;

    shared_mem_arbiter #(
        .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)
    ) dut (
        .clock(clock), .rstN(rstN), .req(req), .reqWe(reqWe), .reqAddr(reqAddr),
        .reqData(reqData), .gnt(gnt), .ack(ack), .rdData(rdData), .busy(busy),
        .memAddr(memAddr), .memWrData(memWrData), .memWe(memWe), .memRe(memRe),
        .memRdData(memRdData)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Memory responder: read data appears L cycles after the memRe cycle.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] pipe0 = '0, pipe1 = '0;
    always @(posedge clock) begin
        pipe0 <= memRe ? mem[memAddr] : '0;
        pipe1 <= pipe0;
        if (memWe) mem[memAddr] <= memWrData;
    end
    assign memRdData = pipe1;

    // Transaction model: m_t counts cycles since the accepting edge.
    logic [DW-1:0] m_mem [4096];
    bit            m_act   = 0;
    int            m_t     = 0;
    int            m_idx   = 0;
    int            m_last  = NC - 1;
    bit            m_we    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_rd    = '0;
    logic [AW-1:0] m_maddr = '0;
    logic [DW-1:0] m_mwd   = '0;

    always @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            m_act = 0; m_t = 0; m_last = NC - 1;
            m_rd = '0; m_maddr = '0; m_mwd = '0;
        end else if (m_act) begin
            m_t++;
            if (m_t == L + 1 && !m_we) m_rd = m_mem[m_addr];
            if (m_t == L + 2) begin
                m_act  = 0;
                m_last = m_idx;
            end
        end else if (req != 0) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (((req >> c) & 4'b1) != 0) begin
                    m_idx = c;
                    break;
                end
            end
            m_we    = ((reqWe >> m_idx) & 4'b1) != 0;
            m_addr  = AW'(reqAddr >> (m_idx * AW));
            m_wd    = DW'(reqData >> (m_idx * DW));
            m_act   = 1;
            m_t     = 0;
            m_maddr = m_addr;
            m_mwd   = m_wd;
            if (m_we) m_mem[m_addr] = m_wd;
        end
    end

    // Per-cycle compare plus event logs used by the directed checks.
    int            glog_idx[$];
    int            glog_cyc[$];
    logic [NC-1:0] prev_gnt = '0;
    int            n_re = 0, n_we = 0, n_ack1 = 0;
    logic [AW-1:0] re_addr = '0, we_addr = '0;
    logic [DW-1:0] we_data = '0;

    always @(negedge clock) begin
        logic [NC-1:0] e_gnt, e_ack;
        e_gnt = m_act ? NC'(1 << m_idx) : '0;
        e_ack = (m_act && m_t == L + 1) ? NC'(1 << m_idx) : '0;
        chk("cmp_gnt", 32'(gnt), 32'(e_gnt));
        chk("cmp_ack", 32'(ack), 32'(e_ack));
        chk("cmp_busy", 32'(busy), 32'(m_act));
        chk("cmp_memRe", 32'(memRe), 32'(m_act && m_t == 0 && !m_we));
        chk("cmp_memWe", 32'(memWe), 32'(m_act && m_t == 0 && m_we));
        chk("cmp_memAddr", 32'(memAddr), 32'(m_maddr));
        chk("cmp_memWrData", 32'(memWrData), 32'(m_mwd));
        chk("cmp_rdData", 32'(rdData), 32'(m_rd));
        if (gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < NC; i++) if (gnt == NC'(1 << i)) glog_idx.push_back(i);
            glog_cyc.push_back(cyc);
        end
        prev_gnt = gnt;
        if (memRe) begin n_re++; re_addr = memAddr; end
        if (memWe) begin n_we++; we_addr = memAddr; we_data = memWrData; end
        if (ack[1]) n_ack1++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_core(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqWe[c]            = we;
        reqAddr[c*AW +: AW] = a;
        reqData[c*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int c, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ack[c]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", 32'(c), 32'hFFFF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    int s, at, re0, we0, a1, n4;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rstN = 1'b0; req = '0; reqWe = '0; reqAddr = '0; reqData = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]   = DW'(i * 7 + 3);
            m_mem[i] = DW'(i * 7 + 3);
        end
        mem[12'h0A5]   = 12'h123;
        m_mem[12'h0A5] = 12'h123;
        step(); step(); step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdData", 32'(rdData), 0);
        rstN = 1'b1;
        step();

        // Single read from core 2.
        set_core(2, 0, 12'h0A5, 12'h000);
        req = 4'b0100; s = cyc; re0 = n_re;
        wait_ack(2, at);
        chk("t1_latency", 32'(at - s), 4);
        chk("t1_rdData", 32'(rdData), 32'h123);
        chk("t1_re_addr", 32'(re_addr), 32'h0A5);
        chk("t1_re_count", 32'(n_re - re0), 1);
        step(); req = '0;

        // Write from core 1.
        set_core(1, 1, 12'h010, 12'hABC);
        req = 4'b0010; re0 = n_re; we0 = n_we;
        wait_ack(1, at);
        chk("t2_rdData_kept", 32'(rdData), 32'h123);
        chk("t2_we_count", 32'(n_we - we0), 1);
        chk("t2_we_addr", 32'(we_addr), 32'h010);
        chk("t2_we_data", 32'(we_data), 32'hABC);
        chk("t2_no_re", 32'(n_re - re0), 0);
        step(); req = '0;

        // All four held continuously after a fresh reset.
        rstN = 1'b0; step(); step();
        glog_idx.delete(); glog_cyc.delete();
        rstN = 1'b1;
        for (int i = 0; i < NC; i++) set_core(i, 0, AW'(12'h100 + i), '0);
        req = 4'b1111;
        for (int i = 0; i < 80 && glog_idx.size() < 5; i++) step();
        chk("t3_grant_count", 32'(glog_idx.size()), 5);
        if (glog_idx.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog_idx[i]), 32'(exp_order[i]));
            for (int i = 0; i < 4; i++) chk("t3_gap", 32'(glog_cyc[i+1] - glog_cyc[i]), 5);
        end
        wait_ack(0, at);
        step(); req = '0;

        // Core 3 served, then 1001: core 0 wins on wrap-around.
        set_core(3, 0, 12'h333, '0);
        req = 4'b1000;
        wait_ack(3, at);
        step(); req = '0;
        set_core(0, 0, 12'h040, '0);
        req = 4'b1001; n4 = glog_idx.size();
        wait_ack(0, at);
        chk("t4_winner", 32'(glog_idx[n4]), 0);
        step(); req = 4'b1000;
        wait_ack(3, at);
        chk("t4_next", 32'(glog_idx[glog_idx.size()-1]), 3);
        step(); req = '0;

        // Core 0 changes address and drops req during WAIT.
        set_core(0, 0, 12'h200, '0);
        req = 4'b0001; re0 = n_re;
        step(); step();
        set_core(0, 0, 12'h300, '0);
        req = '0;
        wait_ack(0, at);
        chk("t5_re_addr", 32'(re_addr), 32'h200);
        chk("t5_rdData", 32'(rdData), 32'hE03);
        chk("t5_re_count", 32'(n_re - re0), 1);
        step();

        // Reset during WAIT aborts; core 0 first afterwards, no stale ack.
        set_core(1, 0, 12'h055, '0);
        req = 4'b0010; a1 = n_ack1;
        step(); step();
        @(posedge clock); #2;
        rstN = 1'b0;
        #1;
        chk("t6_gnt", 32'(gnt), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_memRe", 32'(memRe), 0);
        chk("t6_ack", 32'(ack), 0);
        chk("t6_rdData", 32'(rdData), 0);
        set_core(0, 0, 12'h040, '0);
        req = 4'b0011;
        step(); step();
        glog_idx.delete(); glog_cyc.delete();
        rstN = 1'b1;
        wait_ack(0, at);
        chk("t6_first", 32'(glog_idx.size() > 0 ? glog_idx[0] : 99), 0);
        chk("t6_no_stale", 32'(n_ack1 - a1), 0);
        step(); req = 4'b0010;
        wait_ack(1, at);
        step(); req = '0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
